s2mm_packetizer: RTL
====================

# s2mm_packetizer

Packs the 16-bit sample stream produced by the FIR DUT into 32-bit AXI4-Stream beats, framed into fixed-length packets with `tlast`, for the S2MM capture DMA. A small FIFO absorbs DMA backpressure; words that cannot be stored are dropped and counted, never stalling the DUT. The block sits between the DUT `data_out` and the `sink_s2mm_*` slave port of the base design, replacing the constant `tvalid=1`, `tlast=0` tie-offs.

## Interface
- `SAMPLE_W`, 16: input sample width. Two samples per beat.
- `PKT_LEN`, 256: beats per packet. Legal range 2..65535.
- `FIFO_DEPTH`, 16: FIFO depth in words. Power of two, ≥4.

Ports:
- `clk` in 1: capture clock, the DUT clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: capture enable. A rising edge starts a session. A falling edge flushes.
- `in_data` in SAMPLE_W: DUT sample.
- `in_valid` in 1: sample qualifier. Accepted only while in RUN.
- `m_axis_tdata` out 32: output beat.
- `m_axis_tkeep` out 4: byte qualifiers.
- `m_axis_tlast` out 1: last beat of a packet.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: DMA ready.
- `pkt_cnt` out 16: packets fully transferred. Wraps.
- `drop_cnt` out 16: words dropped. Saturates at 16'hFFFF.
- `overflow` out 1: sticky. Set on the first drop.
- `busy` out 1: high when state ≠ IDLE or the FIFO is not empty.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN when `enable`=1. The same transition clears `pkt_cnt`, `drop_cnt`, `overflow`, the half-word flag and the beat counter.
  - RUN → FLUSH when `enable`=0.
  - FLUSH → IDLE once the flush beat is pushed, or immediately if no beat is needed.
- Packing:
  - The first accepted sample goes to `tdata[15:0]` and sets the half-word flag.
  - The second goes to `tdata[31:16]`, completing a word with `tkeep`=4'hF.
- Framing:
  - The push-side beat counter counts words actually written to the FIFO.
  - The word written at count PKT_LEN-1 carries `tlast`=1, and the counter wraps to 0.
  - Dropped words do not advance the counter, so every non-flush packet is exactly PKT_LEN beats.
- Overflow handling:
  - A completed word that meets a full FIFO with no pop in the same cycle is discarded.
  - `drop_cnt` is incremented (saturating) and `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO is a legal push, not a drop.
- Flush, performed in FLUSH:
  - Half-word pending: push {16'h0, half} with `tkeep`=4'h3 and `tlast`=1.
  - No half-word and beat counter ≠ 0: push a null beat, `tdata`=0, `tkeep`=4'h0, `tlast`=1.
  - No half-word and beat counter = 0: nothing is pushed.
  - Flush beats are never dropped. FLUSH holds until the FIFO has space.
  - `enable` is ignored in FLUSH.
- `pkt_cnt` increments on each handshake (`tvalid & tready`) of a beat with `tlast`=1.
- `in_valid` is ignored in IDLE and FLUSH, and on the cycle `enable` falls.

## Timing
- Reset values:
  - All outputs 0: `tvalid`, `tlast`, `tkeep`, `tdata`, `pkt_cnt`, `drop_cnt`, `overflow`, `busy`.
  - State IDLE, FIFO empty.
- Reset asserted mid-packet discards FIFO contents and the partial word immediately (asynchronously).
- Latency: the second sample of a pair is accepted at edge t, the word is written at edge t+1, and `m_axis_tvalid` rises in cycle t+1. The FIFO is registered-output, not fall-through.
- AXIS rules:
  - `tdata`, `tkeep` and `tlast` stay stable while `tvalid`=1 and `tready`=0.
  - `tvalid` does not depend combinationally on `tready`.
- Throughput: one beat per cycle sustained on pop. Input at most one sample per cycle means at most 0.5 beat per cycle.
- Empty FIFO gives `tvalid`=0. Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Structure
- Package `s2mm_pkg` holds:
  - state enum (IDLE/RUN/FLUSH);
  - `KEEP_FULL`=4'hF, `KEEP_HALF`=4'h3, `KEEP_NULL`=4'h0;
  - FIFO entry layout {tlast, tkeep, tdata} = 37 bits.
- Sub-module `axis_sync_fifo` is a single-clock, 37-bit wide, FIFO_DEPTH deep FIFO with full/empty and a registered output stage.
- The packer, framer, FSM and counters live in `s2mm_packetizer`.

## Test plan
1. PKT_LEN=4, `tready`=1, samples 0x0001..0x0008 back-to-back → beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 (keep F), `tlast` on the 4th, `pkt_cnt`=1, `drop_cnt`=0.
2. PKT_LEN=4, samples 0x000A, 0x000B, 0x000C, then `enable`=0 → 0x000B000A keep F `tlast`=0, then 0x0000000C keep 3 `tlast`=1. `busy` falls after drain.
3. PKT_LEN=4, 4 samples, then disable → 2 full beats, then a null beat (keep 0, `tlast`=1).
4. FIFO_DEPTH=4, `tready`=0, 12 samples → 4 words stored, `drop_cnt`=2, `overflow`=1. Release `tready` → the first 4 words emerge in order with `tdata` stable while stalled.
5. FIFO full with `tready`=1 exactly when a new word completes → word accepted, `drop_cnt` unchanged.
6. `rst` pulsed mid-packet (beat 2 of 4) → `tvalid`=0 and counters 0 immediately. Re-enable with 8 samples → a fresh packet with `tlast` on beat 4.

Source files
------------

// File: rtl/s2mm_pkg.sv
// Shared types and constants for the S2MM packetizer: FSM states,
// byte-keep encodings and the layout of one FIFO entry.
package s2mm_pkg;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int ENTRY_W = 1 + KEEP_W + DATA_W;

  localparam logic [KEEP_W-1:0] KEEP_FULL = 4'hF;
  localparam logic [KEEP_W-1:0] KEEP_HALF = 4'h3;
  localparam logic [KEEP_W-1:0] KEEP_NULL = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // One stored beat; packs to {tlast, tkeep, tdata} = 37 bits.
  typedef struct packed {
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
  } fifo_entry_t;

endpackage

// File: rtl/s2mm_packetizer_if.sv
// AXI4-Stream beat bundle between the packetizer and the S2MM DMA.
interface s2mm_packetizer_if;
  import s2mm_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO of fifo_entry_t with a registered output stage.
// The output register always holds the head entry; a write into an empty
// FIFO lands in it on the same edge, so valid rises one edge after the write.
module axis_sync_fifo
  import s2mm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  output logic        full,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        rd_valid
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t out_q, out_d;
  logic        valid_q, valid_d;
  logic        empty_s, do_push_s, do_pop_s;

  // Pointer arithmetic, full/empty (extra pointer bit) and next head entry.
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop_s  = rd_en && !empty_s;
    do_push_s = wr_en && (!full || do_pop_s);
    wr_ptr_d  = wr_ptr_q + (AW+1)'(do_push_s);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop_s);
    valid_d   = (wr_ptr_d != rd_ptr_d);
    if (do_push_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      out_d = wr_data;
    end else begin
      out_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data  = out_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/s2mm_packetizer.sv
// Packs 16-bit DUT samples into 32-bit AXI4-Stream beats framed into
// PKT_LEN-beat packets. Completed words are staged one cycle and then
// pushed; a word that meets a full FIFO is dropped and counted so the
// sample source is never stalled. Disabling flushes any partial packet.
module s2mm_packetizer
  import s2mm_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int PKT_LEN    = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  s2mm_packetizer_if.master   m_axis,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         drop_cnt,
  output logic                overflow,
  output logic                busy
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t              state_q, state_d;
  logic                half_q, half_d;
  logic [SAMPLE_W-1:0] half_data_q, half_data_d;
  logic                word_valid_q, word_valid_d;
  logic [DATA_W-1:0]   word_data_q, word_data_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                overflow_q, overflow_d;

  logic        accept_s, pop_s, space_s, push_s;
  fifo_entry_t push_entry_s, fifo_out_s;
  logic        fifo_full_s, fifo_valid_s;

  axis_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_s),
    .wr_data  (push_entry_s),
    .full     (fifo_full_s),
    .rd_en    (m_axis.tready),
    .rd_data  (fifo_out_s),
    .rd_valid (fifo_valid_s)
  );

  // Packing, framing, flush, counters and next-state selection.
  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    half_data_d  = half_data_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    push_s       = 1'b0;
    push_entry_s = '0;

    accept_s = (state_q == ST_RUN) && enable && in_valid;
    pop_s    = m_axis.tready && fifo_valid_s;
    space_s  = !fifo_full_s || pop_s;

    // Pair samples: low half first, high half completes the staged word.
    if (accept_s) begin
      if (half_q) begin
        word_valid_d = 1'b1;
        word_data_d  = {in_data, half_data_q};
        half_d       = 1'b0;
      end else begin
        half_d      = 1'b1;
        half_data_d = in_data;
      end
    end else begin
      half_d = half_q;
    end

    // A staged word always resolves this cycle; flush beats wait behind it.
    if (word_valid_q) begin
      push_entry_s.tlast = (beat_cnt_q == LAST_BEAT);
      push_entry_s.tkeep = KEEP_FULL;
      push_entry_s.tdata = word_data_q;
      if (space_s) begin
        push_s = 1'b1;
      end else begin
        overflow_d = 1'b1;
        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
      end
    end else if (state_q == ST_FLUSH) begin
      push_entry_s.tlast = 1'b1;
      if (half_q) begin
        push_entry_s.tkeep = KEEP_HALF;
        push_entry_s.tdata = {{(DATA_W-SAMPLE_W){1'b0}}, half_data_q};
      end else begin
        push_entry_s.tkeep = KEEP_NULL;
        push_entry_s.tdata = '0;
      end
      if (!half_q && (beat_cnt_q == 16'd0)) begin
        state_d = ST_IDLE;
      end else if (space_s) begin
        push_s  = 1'b1;
        half_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_FLUSH;
      end
    end else begin
      push_s = 1'b0;
    end

    if (push_s) begin
      beat_cnt_d = push_entry_s.tlast ? 16'd0 : beat_cnt_q + 16'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    if (pop_s && fifo_out_s.tlast) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end

    // Session transitions; starting a session clears all session state.
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_RUN;
          pkt_cnt_d  = 16'd0;
          drop_cnt_d = 16'd0;
          overflow_d = 1'b0;
          half_d     = 1'b0;
          beat_cnt_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = state_d;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Session state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      half_q       <= 1'b0;
      half_data_q  <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      beat_cnt_q   <= 16'd0;
      pkt_cnt_q    <= 16'd0;
      drop_cnt_q   <= 16'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      half_data_q  <= half_data_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign m_axis.tdata  = fifo_out_s.tdata;
  assign m_axis.tkeep  = fifo_out_s.tkeep;
  assign m_axis.tlast  = fifo_out_s.tlast;
  assign m_axis.tvalid = fifo_valid_s;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != ST_IDLE) || fifo_valid_s;

endmodule
